// File: rtl/cm0_dap_cdc_pkg.sv
// Shared types and constants for the DAP CDC request/acknowledge receiver.
package cm0_dap_cdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OPEN     = 2'd1,
        ST_CAPT     = 2'd2,
        ST_WAIT_LOW = 2'd3
    } cdc_state_e;

    localparam int SETTLE_CNT_W    = 3;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int SETTLE_MIN      = 0;
    localparam int SETTLE_MAX      = 7;

endpackage

// File: rtl/cm0_dap_cdc_mask_gate.sv
// Bank of dedicated AND2 cells masking the asynchronous data bus.
// Each cell must be kept as-is by the implementation flow (don't-touch, resize allowed).
module cm0_dap_cdc_mask_gate
    import cm0_dap_cdc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             mask_i,
    output logic [WIDTH-1:0] data_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_and2
        and u_and2 (data_o[i], data_i[i], mask_i);
    end

endmodule

// File: rtl/cm0_dap_cdc_rx_capture.sv
// Destination side of the four-phase CDC transfer: synchronise REQ, open the mask, capture, acknowledge.
// Optional feature macro: CM0_DAP_CDC_PROTERR_EN (abort and flag when REQ falls while the mask is open).
module cm0_dap_cdc_rx_capture
    import cm0_dap_cdc_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 1,
    parameter int PRESENT     = 1
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             REQ_ASYNC,
    input  logic [WIDTH-1:0] DATAIN,
    output logic             ACK,
    output logic             MASKn,
    output logic [WIDTH-1:0] DATAOUT,
    output logic             VALID,
`ifdef CM0_DAP_CDC_PROTERR_EN
    output logic             BUSY,
    output logic             PROTERR
`else
    output logic             BUSY
`endif
);

    logic [WIDTH-1:0] masked;

    if (PRESENT != 0) begin : g_core
        logic [SYNC_STAGES-1:0]  sync_q;
        logic                    req_s;
        cdc_state_e              state_q, state_d;
        logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
        logic                    mask_q, mask_d;
        logic                    ack_q, ack_d;
        logic                    valid_q, valid_d;
        logic [WIDTH-1:0]        dataout_q;
        logic                    capture;
`ifdef CM0_DAP_CDC_PROTERR_EN
        logic                    proterr_q, proterr_d;
`endif

        assign req_s = sync_q[SYNC_STAGES-1];

        // The mask gate is the only logic between DATAIN and the capture register.
        cm0_dap_cdc_mask_gate #(
            .WIDTH (WIDTH)
        ) u_mask_gate (
            .data_i (DATAIN),
            .mask_i (mask_q),
            .data_o (masked)
        );

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            mask_d  = mask_q;
            ack_d   = ack_q;
            valid_d = 1'b0;
            capture = 1'b0;
`ifdef CM0_DAP_CDC_PROTERR_EN
            proterr_d = 1'b0;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (req_s) begin
                        state_d = ST_OPEN;
                        mask_d  = 1'b1;
                        cnt_d   = SETTLE_CNT_W'(SETTLE);
                    end
                end
                ST_OPEN: begin
`ifdef CM0_DAP_CDC_PROTERR_EN
                    if (!req_s) begin
                        state_d   = ST_IDLE;
                        mask_d    = 1'b0;
                        proterr_d = 1'b1;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - SETTLE_CNT_W'(1);
                    end else begin
                        state_d = ST_CAPT;
                    end
`else
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - SETTLE_CNT_W'(1);
                    end else begin
                        state_d = ST_CAPT;
                    end
`endif
                end
                ST_CAPT: begin
                    capture = 1'b1;
                    valid_d = 1'b1;
                    ack_d   = 1'b1;
                    mask_d  = 1'b0;
                    state_d = ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    ack_d = 1'b1;
                    if (!req_s) begin
                        ack_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                sync_q    <= '0;
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                mask_q    <= 1'b0;
                ack_q     <= 1'b0;
                valid_q   <= 1'b0;
                dataout_q <= '0;
`ifdef CM0_DAP_CDC_PROTERR_EN
                proterr_q <= 1'b0;
`endif
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], REQ_ASYNC};
                state_q <= state_d;
                cnt_q   <= cnt_d;
                mask_q  <= mask_d;
                ack_q   <= ack_d;
                valid_q <= valid_d;
                if (capture) begin
                    dataout_q <= masked;
                end
`ifdef CM0_DAP_CDC_PROTERR_EN
                proterr_q <= proterr_d;
`endif
            end
        end

        assign ACK     = ack_q;
        assign MASKn   = mask_q;
        assign DATAOUT = dataout_q;
        assign VALID   = valid_q;
        assign BUSY    = (state_q != ST_IDLE);
`ifdef CM0_DAP_CDC_PROTERR_EN
        assign PROTERR = proterr_q;
`endif
    end else begin : g_absent
        logic unused_inputs;

        assign unused_inputs = ^{HCLK, HRESETn, REQ_ASYNC, DATAIN};
        assign masked        = '0;
        assign ACK           = 1'b0;
        assign MASKn         = 1'b0;
        assign DATAOUT       = '0;
        assign VALID         = 1'b0;
        assign BUSY          = 1'b0;
`ifdef CM0_DAP_CDC_PROTERR_EN
        assign PROTERR       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_cm0_dap_cdc_rx_capture.sv
// Scoreboard bench for cm0_dap_cdc_rx_capture across several parameter sets.
// Honours CM0_DAP_CDC_PROTERR_EN when the design is built with it.
module tb_cm0_dap_cdc_rx_capture;

    logic clk;
    logic rstn;

    // A: 32 bit, SYNC 2, SETTLE 1. B: 8 bit, SYNC 3, SETTLE 0. C: 16 bit, SYNC 4, SETTLE 7. Z: absent.
    logic        reqA, ackA, maskA, validA, busyA;
    logic [31:0] dataA, doutA;
    logic        reqB, ackB, maskB, validB, busyB;
    logic [7:0]  dataB, doutB;
    logic        reqC, ackC, maskC, validC, busyC;
    logic [15:0] dataC, doutC;
    logic        reqZ, ackZ, maskZ, validZ, busyZ;
    logic [31:0] dataZ, doutZ;
`ifdef CM0_DAP_CDC_PROTERR_EN
    logic        proterrA, proterrB, proterrC, proterrZ;
`endif

    logic [63:0] qA[$];
    logic [63:0] qB[$];
    logic [63:0] qC[$];
    logic        prevValidA, prevValidB, prevValidC;

    int nCompared;
    int nMismatched;

    cm0_dap_cdc_rx_capture #(.WIDTH(32), .SYNC_STAGES(2), .SETTLE(1), .PRESENT(1)) dutA (
        .HCLK(clk), .HRESETn(rstn), .REQ_ASYNC(reqA), .DATAIN(dataA), .ACK(ackA),
        .MASKn(maskA), .DATAOUT(doutA), .VALID(validA), .BUSY(busyA)
`ifdef CM0_DAP_CDC_PROTERR_EN
        , .PROTERR(proterrA)
`endif
    );

    cm0_dap_cdc_rx_capture #(.WIDTH(8), .SYNC_STAGES(3), .SETTLE(0), .PRESENT(1)) dutB (
        .HCLK(clk), .HRESETn(rstn), .REQ_ASYNC(reqB), .DATAIN(dataB), .ACK(ackB),
        .MASKn(maskB), .DATAOUT(doutB), .VALID(validB), .BUSY(busyB)
`ifdef CM0_DAP_CDC_PROTERR_EN
        , .PROTERR(proterrB)
`endif
    );

    cm0_dap_cdc_rx_capture #(.WIDTH(16), .SYNC_STAGES(4), .SETTLE(7), .PRESENT(1)) dutC (
        .HCLK(clk), .HRESETn(rstn), .REQ_ASYNC(reqC), .DATAIN(dataC), .ACK(ackC),
        .MASKn(maskC), .DATAOUT(doutC), .VALID(validC), .BUSY(busyC)
`ifdef CM0_DAP_CDC_PROTERR_EN
        , .PROTERR(proterrC)
`endif
    );

    cm0_dap_cdc_rx_capture #(.WIDTH(32), .SYNC_STAGES(2), .SETTLE(1), .PRESENT(0)) dutZ (
        .HCLK(clk), .HRESETn(rstn), .REQ_ASYNC(reqZ), .DATAIN(dataZ), .ACK(ackZ),
        .MASKn(maskZ), .DATAOUT(doutZ), .VALID(validZ), .BUSY(busyZ)
`ifdef CM0_DAP_CDC_PROTERR_EN
        , .PROTERR(proterrZ)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Signal selector: 0 VALID, 1 ACK, 2 MASKn, 3 PROTERR, 4 BUSY.
    function automatic logic probe(input int d, input int s);
        logic [4:0] v;
        v = '0;
        case (d)
            0: v = {busyA, 1'b0, maskA, ackA, validA};
            1: v = {busyB, 1'b0, maskB, ackB, validB};
            default: v = {busyC, 1'b0, maskC, ackC, validC};
        endcase
`ifdef CM0_DAP_CDC_PROTERR_EN
        case (d)
            0: v[3] = proterrA;
            1: v[3] = proterrB;
            default: v[3] = proterrC;
        endcase
`endif
        return v[s];
    endfunction

    task automatic setReq(input int d, input logic v);
        case (d)
            0: reqA = v;
            1: reqB = v;
            default: reqC = v;
        endcase
    endtask

    task automatic setData(input int d, input logic [63:0] data);
        case (d)
            0: dataA = data[31:0];
            1: dataB = data[7:0];
            default: dataC = data[15:0];
        endcase
    endtask

    task automatic pushExp(input int d, input logic [63:0] data);
        case (d)
            0: qA.push_back(64'(data[31:0]));
            1: qB.push_back(64'(data[7:0]));
            default: qC.push_back(64'(data[15:0]));
        endcase
    endtask

    task automatic countEdges(input int d, input int s, input logic level, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (probe(d, s) !== level && n < limit);
    endtask

    // One full four-phase transfer with the sender answering ACK immediately.
    task automatic applyStimulus(input int d, input logic [63:0] data, input int sync, input int settle);
        int nOpen, nCap, nFall;
        setData(d, data);
        pushExp(d, data);
        setReq(d, 1'b1);
        countEdges(d, 2, 1'b1, 60, nOpen);
        checkOutput($sformatf("maskOpen%0d", d), 64'(nOpen), 64'(sync + 1));
        countEdges(d, 0, 1'b1, 60, nCap);
        checkOutput($sformatf("captureLat%0d", d), 64'(nOpen + nCap), 64'(sync + settle + 3));
        checkOutput($sformatf("ackMaskAtCapture%0d", d), 64'({probe(d, 1), probe(d, 2)}), 64'b10);
        setReq(d, 1'b0);
        countEdges(d, 1, 1'b0, 60, nFall);
        checkOutput($sformatf("ackFall%0d", d), 64'(nFall), 64'(sync + 1));
        checkOutput($sformatf("period%0d", d), 64'(nOpen + nCap + nFall), 64'(2 * sync + settle + 4));
        checkOutput($sformatf("busyIdle%0d", d), 64'(probe(d, 4)), 64'd0);
    endtask

    // Scoreboard monitors: every VALID pops one expected word; masked bus of A must be 0 while closed.
    always @(negedge clk) begin
        if (rstn && validA) begin
            if (qA.size() == 0) checkOutput("unexpectedValidA", 64'(validA), 64'd0);
            else                checkOutput("doutA", 64'(doutA), qA.pop_front());
            checkOutput("validWidthA", 64'(prevValidA), 64'd0);
        end
        if (rstn && !maskA) checkOutput("maskedZeroA", 64'(dutA.masked), 64'd0);
        prevValidA = rstn && validA;
    end

    always @(negedge clk) begin
        if (rstn && validB) begin
            if (qB.size() == 0) checkOutput("unexpectedValidB", 64'(validB), 64'd0);
            else                checkOutput("doutB", 64'(doutB), qB.pop_front());
            checkOutput("validWidthB", 64'(prevValidB), 64'd0);
        end
        prevValidB = rstn && validB;
    end

    always @(negedge clk) begin
        if (rstn && validC) begin
            if (qC.size() == 0) checkOutput("unexpectedValidC", 64'(validC), 64'd0);
            else                checkOutput("doutC", 64'(doutC), qC.pop_front());
            checkOutput("validWidthC", 64'(prevValidC), 64'd0);
        end
        prevValidC = rstn && validC;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] lastA;
        int n;
        nCompared   = 0;
        nMismatched = 0;
        prevValidA  = 1'b0;
        prevValidB  = 1'b0;
        prevValidC  = 1'b0;
        rstn  = 1'b0;
        reqA  = 1'b0; reqB = 1'b0; reqC = 1'b0; reqZ = 1'b0;
        dataA = '0;   dataB = '0;  dataC = '0;  dataZ = '0;
        repeat (3) tick();

        checkOutput("rstAckA",   64'(ackA),   64'd0);
        checkOutput("rstMaskA",  64'(maskA),  64'd0);
        checkOutput("rstDoutA",  64'(doutA),  64'd0);
        checkOutput("rstValidA", 64'(validA), 64'd0);
        checkOutput("rstBusyA",  64'(busyA),  64'd0);
        checkOutput("rstB", 64'({ackB, maskB, validB, busyB, doutB}), 64'd0);
        checkOutput("rstC", 64'({ackC, maskC, validC, busyC, doutC}), 64'd0);
        rstn = 1'b1;
        repeat (2) tick();

        applyStimulus(0, 64'hA5A5_5A5A, 2, 1);
        applyStimulus(0, 64'hFFFF_FFFF, 2, 1);
        applyStimulus(0, 64'h0000_0001, 2, 1);
        applyStimulus(0, 64'h1234_5678, 2, 1);
        lastA = 32'h1234_5678;

        for (int i = 0; i < 6; i++) begin
            dataA = $urandom;
            tick();
            checkOutput("idleHoldA", 64'({ackA, validA, doutA}), 64'({2'b00, lastA}));
        end

        dataA = 32'hC3C3_3C3C;
        pushExp(0, 64'hC3C3_3C3C);
        reqA = 1'b1;
        countEdges(0, 0, 1'b1, 60, n);
        checkOutput("waitLowLatA", 64'(n), 64'd6);
        for (int i = 0; i < 5; i++) begin
            tick();
            dataA = $urandom;
            checkOutput("waitLowHoldA", 64'({ackA, validA, maskA, doutA}), 64'({3'b100, 32'hC3C3_3C3C}));
        end
        reqA = 1'b0;
        countEdges(0, 1, 1'b0, 60, n);
        checkOutput("waitLowFallA", 64'(n), 64'd3);

        dataA = 32'h0BAD_F00D;
        reqA  = 1'b1;
        countEdges(0, 2, 1'b1, 60, n);
        checkOutput("rstOpenReachA", 64'({busyA, n[3:0]}), 64'h13);
        rstn = 1'b0;
        #1;
        checkOutput("rstOpenA", 64'({ackA, maskA, validA, busyA, doutA}), 64'd0);
        repeat (2) tick();
        pushExp(0, 64'h0BAD_F00D);
        rstn = 1'b1;
        countEdges(0, 0, 1'b1, 60, n);
        checkOutput("reacquireLatA", 64'(n), 64'd6);
        reqA = 1'b0;
        countEdges(0, 1, 1'b0, 60, n);
        checkOutput("reacquireFallA", 64'(n), 64'd3);
        repeat (10) tick();

        applyStimulus(1, 64'h5A, 3, 0);
        applyStimulus(1, 64'hC3, 3, 0);
        applyStimulus(2, 64'hBEEF, 4, 7);
        applyStimulus(2, 64'h1234, 4, 7);

        dataC = 16'hA0A0;
        reqC  = 1'b1;
        countEdges(2, 2, 1'b1, 60, n);
        checkOutput("dropOpenReachC", 64'(n), 64'd5);
        reqC = 1'b0;
`ifdef CM0_DAP_CDC_PROTERR_EN
        countEdges(2, 3, 1'b1, 60, n);
        checkOutput("proterrLatC", 64'(n), 64'd5);
        checkOutput("proterrAbortC", 64'({maskC, busyC, ackC, validC}), 64'd0);
        tick();
        checkOutput("proterrPulseC", 64'(proterrC), 64'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            checkOutput("proterrQuietC", 64'({ackC, validC, doutC}), 64'h0_1234);
        end
`else
        pushExp(2, 64'hA0A0);
        countEdges(2, 0, 1'b1, 60, n);
        checkOutput("dropCaptureC", 64'(n), 64'd9);
        checkOutput("dropAckHighC", 64'(ackC), 64'd1);
        countEdges(2, 1, 1'b0, 60, n);
        checkOutput("dropAckFallC", 64'(n), 64'd1);
        repeat (5) tick();
`endif

        for (int i = 0; i < 40; i++) begin
            reqZ  = 1'($urandom_range(0, 1));
            dataZ = $urandom;
            tick();
            checkOutput("absentZ", 64'({ackZ, maskZ, validZ, busyZ, doutZ}), 64'd0);
        end

        repeat (10) tick();
        checkOutput("queueEmptyA", 64'(qA.size()), 64'd0);
        checkOutput("queueEmptyB", 64'(qB.size()), 64'd0);
        checkOutput("queueEmptyC", 64'(qC.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
